// File: rtl/pipe_hazard_unit_if.sv
// ID-stage request and hazard-control response bundle for pipe_hazard_unit.
// master = pipeline control driving ID info, slave = the hazard unit.
interface pipe_hazard_unit_if #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned SEL_W          = 2
);
    logic                      pipe_en_i;
    logic                      id_valid_i;
    logic [REG_ADDR_WIDTH-1:0] id_rs1_i;
    logic [REG_ADDR_WIDTH-1:0] id_rs2_i;
    logic                      id_rs1_use_i;
    logic                      id_rs2_use_i;
    logic [REG_ADDR_WIDTH-1:0] id_rd_i;
    logic                      id_wb_en_i;
    logic                      id_is_load_i;
    logic                      redirect_i;
    logic                      stall_o;
    logic                      bubble_o;
    logic                      flush_if_id_o;
    logic [SEL_W-1:0]          fwd_rs1_sel_o;
    logic [SEL_W-1:0]          fwd_rs2_sel_o;
    logic [31:0]               stall_cnt_o;

    modport master (
        output pipe_en_i, id_valid_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
        output id_rd_i, id_wb_en_i, id_is_load_i, redirect_i,
        input  stall_o, bubble_o, flush_if_id_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o
    );

    modport slave (
        input  pipe_en_i, id_valid_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
        input  id_rd_i, id_wb_en_i, id_is_load_i, redirect_i,
        output stall_o, bubble_o, flush_if_id_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller driven by a shift-register writer scoreboard.
// Define HAZARD_FORWARD_EN for forwarding + load-latency stalls; otherwise every match stalls.
module pipe_hazard_unit #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned FWD_DEPTH      = 3,
    parameter int unsigned LOAD_LAT       = 1,
    parameter int unsigned SEL_W          = $clog2(FWD_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_unit_if.slave hz
);

    logic [FWD_DEPTH-1:0]      sb_v_q, sb_v_d;
    logic [FWD_DEPTH-1:0]      sb_ld_q, sb_ld_d;
    logic [REG_ADDR_WIDTH-1:0] sb_rd_q [FWD_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] sb_rd_d [FWD_DEPTH];
    logic [31:0]               stall_cnt_q, stall_cnt_d;

    logic [REG_ADDR_WIDTH-1:0] src [2];
    logic [1:0]                src_use;
    logic [1:0]                hit;
    logic [1:0]                hit_early;
    logic [SEL_W-1:0]          hit_sel [2];
    logic                      stall_raw;
    logic                      active;
    logic                      stall;
    logic                      bubble;

    // Lowest matching age wins; the oldest entry retires before the consumer reads.
    always_comb begin
        src[0]     = hz.id_rs1_i;
        src[1]     = hz.id_rs2_i;
        src_use[0] = hz.id_rs1_use_i;
        src_use[1] = hz.id_rs2_use_i;
        hit        = '0;
        hit_early  = '0;
        hit_sel[0] = '0;
        hit_sel[1] = '0;
        for (int s = 0; s < 2; s++) begin
            for (int k = int'(FWD_DEPTH) - 2; k >= 0; k--) begin
                if (sb_v_q[k] && (sb_rd_q[k] == src[s]) && (src[s] != '0) && src_use[s]) begin
                    hit[s]       = 1'b1;
                    hit_early[s] = sb_ld_q[k] && (k < int'(LOAD_LAT));
                    hit_sel[s]   = SEL_W'(k + 1);
                end
            end
        end
    end

`ifdef HAZARD_FORWARD_EN
    assign stall_raw = |(hit & hit_early);
`else
    assign stall_raw = |hit;
`endif

    // Reset forces the combinational controls low without waiting for an edge.
    assign active = hz.pipe_en_i & rst_n;
    assign stall  = active & hz.id_valid_i & ~hz.redirect_i & stall_raw;
    assign bubble = stall | (active & hz.redirect_i);

    assign hz.stall_o       = stall;
    assign hz.bubble_o      = bubble;
    assign hz.flush_if_id_o = active & hz.redirect_i;
    assign hz.stall_cnt_o   = stall_cnt_q;

    always_comb begin
        sb_v_d      = sb_v_q;
        sb_ld_d     = sb_ld_q;
        sb_rd_d     = sb_rd_q;
        stall_cnt_d = stall_cnt_q;
        if (hz.pipe_en_i) begin
            for (int k = int'(FWD_DEPTH) - 1; k > 0; k--) begin
                sb_v_d[k]  = sb_v_q[k-1];
                sb_ld_d[k] = sb_ld_q[k-1];
                sb_rd_d[k] = sb_rd_q[k-1];
            end
            sb_v_d[0]  = hz.id_valid_i & hz.id_wb_en_i & (hz.id_rd_i != '0) & ~bubble;
            sb_ld_d[0] = hz.id_is_load_i;
            sb_rd_d[0] = hz.id_rd_i;
        end
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_v_q      <= '0;
            sb_ld_q     <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < int'(FWD_DEPTH); k++) begin
                sb_rd_q[k] <= '0;
            end
        end else begin
            sb_v_q      <= sb_v_d;
            sb_ld_q     <= sb_ld_d;
            sb_rd_q     <= sb_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    logic unused_tail;
    assign unused_tail = sb_v_q[FWD_DEPTH-1] ^ sb_ld_q[FWD_DEPTH-1] ^ (^sb_rd_q[FWD_DEPTH-1]);

`ifdef HAZARD_FORWARD_EN
    logic [SEL_W-1:0] sel1_q, sel1_d;
    logic [SEL_W-1:0] sel2_q, sel2_d;

    always_comb begin
        sel1_d = sel1_q;
        sel2_d = sel2_q;
        if (hz.pipe_en_i) begin
            sel1_d = bubble ? '0 : hit_sel[0];
            sel2_d = bubble ? '0 : hit_sel[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel1_q <= '0;
            sel2_q <= '0;
        end else begin
            sel1_q <= sel1_d;
            sel2_q <= sel2_d;
        end
    end

    assign hz.fwd_rs1_sel_o = sel1_q;
    assign hz.fwd_rs2_sel_o = sel2_q;
`else
    logic unused_fwd;
    assign unused_fwd = (^hit_early) ^ (^hit_sel[0]) ^ (^hit_sel[1]);

    assign hz.fwd_rs1_sel_o = '0;
    assign hz.fwd_rs2_sel_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios plus random traffic
// against an in-flight-writer list model.
module tb_pipe_hazard_unit;
    localparam int unsigned RW = 5;
    localparam int unsigned D  = 3;
    localparam int unsigned LL = 1;
    localparam int unsigned SW = $clog2(D);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_unit_if #(.REG_ADDR_WIDTH(RW), .SEL_W(SW)) hif ();

    pipe_hazard_unit #(
        .REG_ADDR_WIDTH(RW),
        .FWD_DEPTH     (D),
        .LOAD_LAT      (LL),
        .SEL_W         (SW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hif.slave)
    );

    typedef struct {
        bit v;
        int rd;
        bit ld;
    } writer_t;

    // flight[a] = writer that left ID a cycles ago
    writer_t        flight [D];
    logic [SW-1:0]  m_sel1, m_sel2, n_sel1, n_sel2;
    logic [31:0]    m_cnt;
    bit             e_stall, e_bubble, e_flush;
    bit             l_valid, l_wb, l_ld, l_en;
    int             l_rd;
    int             n_checks = 0;
    int             n_pass   = 0;

    function automatic void model_clear();
        for (int a = 0; a < int'(D); a++) flight[a] = '{v: 1'b0, rd: 0, ld: 1'b0};
        m_sel1 = '0;
        m_sel2 = '0;
        m_cnt  = '0;
    endfunction

    function automatic void model_src(input int s, input bit use_s, output bit st, output int sel);
        st  = 1'b0;
        sel = 0;
        if (!use_s || s == 0) return;
        for (int a = 0; a < int'(D) - 1; a++) begin
            if (flight[a].v && flight[a].rd == s) begin
`ifdef HAZARD_FORWARD_EN
                st  = flight[a].ld && (a < int'(LL));
                sel = a + 1;
`else
                st  = 1'b1;
`endif
                return;
            end
        end
    endfunction

    task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input int rd, input bit wb, input bit ld, input bit redir, input bit en);
        bit st1, st2, act;
        int s1, s2;
        hif.pipe_en_i    = en;
        hif.id_valid_i   = v;
        hif.id_rs1_i     = RW'(r1);
        hif.id_rs2_i     = RW'(r2);
        hif.id_rs1_use_i = u1;
        hif.id_rs2_use_i = u2;
        hif.id_rd_i      = RW'(rd);
        hif.id_wb_en_i   = wb;
        hif.id_is_load_i = ld;
        hif.redirect_i   = redir;
        l_valid = v; l_rd = rd; l_wb = wb; l_ld = ld; l_en = en;
        #1;
        model_src(r1, u1, st1, s1);
        model_src(r2, u2, st2, s2);
        act      = en && (rst_n === 1'b1);
        e_flush  = act && redir;
        e_stall  = act && v && !redir && (st1 || st2);
        e_bubble = e_stall || e_flush;
        n_sel1   = e_bubble ? '0 : SW'(s1);
        n_sel2   = e_bubble ? '0 : SW'(s2);
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && l_en) begin
            for (int a = int'(D) - 1; a > 0; a--) flight[a] = flight[a-1];
            flight[0] = '{v: l_valid && l_wb && (l_rd != 0) && !e_bubble, rd: l_rd, ld: l_ld};
`ifdef HAZARD_FORWARD_EN
            m_sel1 = n_sel1;
            m_sel2 = n_sel2;
`endif
            if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        n_checks++; if (hif.stall_o !== 1'b0) $display("FAIL reset stall: got %b want 0", hif.stall_o); else n_pass++;
        n_checks++; if (hif.bubble_o !== 1'b0) $display("FAIL reset bubble: got %b want 0", hif.bubble_o); else n_pass++;
        n_checks++; if (hif.flush_if_id_o !== 1'b0) $display("FAIL reset flush: got %b want 0", hif.flush_if_id_o); else n_pass++;
        n_checks++; if (hif.fwd_rs1_sel_o !== '0) $display("FAIL reset sel1: got %0d want 0", hif.fwd_rs1_sel_o); else n_pass++;
        n_checks++; if (hif.fwd_rs2_sel_o !== '0) $display("FAIL reset sel2: got %0d want 0", hif.fwd_rs2_sel_o); else n_pass++;
        n_checks++; if (hif.stall_cnt_o !== 32'd0) $display("FAIL reset cnt: got %0d want 0", hif.stall_cnt_o); else n_pass++;
    endtask

`ifdef HAZARD_FORWARD_EN
    task automatic test_fwd_alu();
        do_reset();
        drive(1'b1, 0, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b1);   // addi x5,x0,imm
        tick();
        drive(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b1);   // add x6,x5,x5
        n_checks++; if (hif.stall_o !== 1'b0) $display("FAIL alu stall: got %b want 0", hif.stall_o); else n_pass++;
        tick();
        idle();
        n_checks++; if (hif.fwd_rs1_sel_o !== SW'(1)) $display("FAIL alu sel1: got %0d want 1", hif.fwd_rs1_sel_o); else n_pass++;
        n_checks++; if (hif.fwd_rs2_sel_o !== SW'(1)) $display("FAIL alu sel2: got %0d want 1", hif.fwd_rs2_sel_o); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 2, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0, 1'b1);   // lw x7
        tick();
        drive(1'b1, 7, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b1);   // add x8,x7,x0
        n_checks++; if (hif.stall_o !== 1'b1) $display("FAIL ldu stall1: got %b want 1", hif.stall_o); else n_pass++;
        n_checks++; if (hif.bubble_o !== 1'b1) $display("FAIL ldu bubble1: got %b want 1", hif.bubble_o); else n_pass++;
        tick();
        drive(1'b1, 7, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (hif.stall_o !== 1'b0) $display("FAIL ldu stall2: got %b want 0", hif.stall_o); else n_pass++;
        n_checks++; if (hif.stall_cnt_o !== 32'd1) $display("FAIL ldu cnt: got %0d want 1", hif.stall_cnt_o); else n_pass++;
        tick();
        idle();
        n_checks++; if (hif.fwd_rs1_sel_o !== SW'(2)) $display("FAIL ldu sel1: got %0d want 2", hif.fwd_rs1_sel_o); else n_pass++;
        n_checks++; if (hif.fwd_rs2_sel_o !== '0) $display("FAIL ldu sel2: got %0d want 0", hif.fwd_rs2_sel_o); else n_pass++;
    endtask
`else
    task automatic test_no_fwd();
        do_reset();
        drive(1'b1, 0, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (hif.stall_o !== ((c < int'(D) - 1) ? 1'b1 : 1'b0))
                $display("FAIL nofwd stall cyc %0d: got %b", c, hif.stall_o);
            else n_pass++;
            tick();
        end
        idle();
        n_checks++; if (hif.stall_cnt_o !== 32'(D - 1)) $display("FAIL nofwd cnt: got %0d want %0d", hif.stall_cnt_o, D - 1); else n_pass++;
        n_checks++; if (hif.fwd_rs1_sel_o !== '0) $display("FAIL nofwd sel1: got %0d want 0", hif.fwd_rs1_sel_o); else n_pass++;
        n_checks++; if (hif.fwd_rs2_sel_o !== '0) $display("FAIL nofwd sel2: got %0d want 0", hif.fwd_rs2_sel_o); else n_pass++;
    endtask
`endif

    task automatic test_x0();
        do_reset();
        drive(1'b1, 1, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 0, 1'b1, 0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (hif.stall_o !== 1'b0) $display("FAIL x0 stall: got %b want 0", hif.stall_o); else n_pass++;
        tick();
        idle();
        n_checks++; if (hif.fwd_rs1_sel_o !== '0) $display("FAIL x0 sel1: got %0d want 0", hif.fwd_rs1_sel_o); else n_pass++;
        n_checks++; if (hif.fwd_rs2_sel_o !== '0) $display("FAIL x0 sel2: got %0d want 0", hif.fwd_rs2_sel_o); else n_pass++;
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1'b1, 2, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 7, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0, 1'b1, 1'b1);   // load-use, redirected
        n_checks++; if (hif.stall_o !== 1'b0) $display("FAIL redir stall: got %b want 0", hif.stall_o); else n_pass++;
        n_checks++; if (hif.bubble_o !== 1'b1) $display("FAIL redir bubble: got %b want 1", hif.bubble_o); else n_pass++;
        n_checks++; if (hif.flush_if_id_o !== 1'b1) $display("FAIL redir flush: got %b want 1", hif.flush_if_id_o); else n_pass++;
        tick();
        drive(1'b1, 9, 1'b1, 9, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (hif.stall_o !== 1'b0) $display("FAIL redir x9 stall: got %b want 0", hif.stall_o); else n_pass++;
        n_checks++; if (hif.stall_cnt_o !== 32'd0) $display("FAIL redir cnt: got %0d want 0", hif.stall_cnt_o); else n_pass++;
        tick();
        idle();
        n_checks++; if (hif.fwd_rs1_sel_o !== '0) $display("FAIL redir sel1: got %0d want 0", hif.fwd_rs1_sel_o); else n_pass++;
    endtask

    task automatic test_pipe_en();
        do_reset();
        drive(1'b1, 2, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0);   // frozen, redirect ignored
        n_checks++; if (hif.stall_o !== 1'b0) $display("FAIL frz stall: got %b want 0", hif.stall_o); else n_pass++;
        n_checks++; if (hif.flush_if_id_o !== 1'b0) $display("FAIL frz flush: got %b want 0", hif.flush_if_id_o); else n_pass++;
        tick();
        drive(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (hif.stall_o !== 1'b1) $display("FAIL frz resume stall: got %b want 1", hif.stall_o); else n_pass++;
        n_checks++; if (hif.stall_cnt_o !== 32'd0) $display("FAIL frz cnt: got %0d want 0", hif.stall_cnt_o); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 3, 1'b1, 6, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (hif.stall_o !== 1'b1) $display("FAIL mid pre stall: got %b want 1", hif.stall_o); else n_pass++;
        n_checks++; if (hif.stall_cnt_o !== m_cnt) $display("FAIL mid pre cnt: got %0d want %0d", hif.stall_cnt_o, m_cnt); else n_pass++;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++; if (hif.stall_o !== 1'b0) $display("FAIL mid rst stall: got %b want 0", hif.stall_o); else n_pass++;
        n_checks++; if (hif.bubble_o !== 1'b0) $display("FAIL mid rst bubble: got %b want 0", hif.bubble_o); else n_pass++;
        n_checks++; if (hif.stall_cnt_o !== 32'd0) $display("FAIL mid rst cnt: got %0d want 0", hif.stall_cnt_o); else n_pass++;
        n_checks++; if (hif.fwd_rs2_sel_o !== '0) $display("FAIL mid rst sel2: got %0d want 0", hif.fwd_rs2_sel_o); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3, 1'b1, 2, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (hif.stall_o !== 1'b0) $display("FAIL post rst stall: got %b want 0", hif.stall_o); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(7) != 0), int'($urandom_range(3)), 1'($urandom),
                  int'($urandom_range(3)), 1'($urandom), int'($urandom_range(3)), 1'($urandom),
                  1'($urandom), ($urandom_range(9) == 0), ($urandom_range(7) != 0));
            n_checks++; if (hif.stall_o !== e_stall) $display("FAIL rnd stall cyc %0d: got %b want %b", i, hif.stall_o, e_stall); else n_pass++;
            n_checks++; if (hif.bubble_o !== e_bubble) $display("FAIL rnd bubble cyc %0d: got %b want %b", i, hif.bubble_o, e_bubble); else n_pass++;
            n_checks++; if (hif.flush_if_id_o !== e_flush) $display("FAIL rnd flush cyc %0d: got %b want %b", i, hif.flush_if_id_o, e_flush); else n_pass++;
            n_checks++; if (hif.fwd_rs1_sel_o !== m_sel1) $display("FAIL rnd sel1 cyc %0d: got %0d want %0d", i, hif.fwd_rs1_sel_o, m_sel1); else n_pass++;
            n_checks++; if (hif.fwd_rs2_sel_o !== m_sel2) $display("FAIL rnd sel2 cyc %0d: got %0d want %0d", i, hif.fwd_rs2_sel_o, m_sel2); else n_pass++;
            n_checks++; if (hif.stall_cnt_o !== m_cnt) $display("FAIL rnd cnt cyc %0d: got %0d want %0d", i, hif.stall_cnt_o, m_cnt); else n_pass++;
            tick();
        end
    endtask

    initial begin
        idle();
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
`ifdef HAZARD_FORWARD_EN
        test_fwd_alu();
        test_load_use();
`else
        test_no_fwd();
`endif
        test_x0();
        test_redirect();
        test_pipe_en();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard, forwarding and flush controller for the in-order RISC-V pipeline. Replaces the current hazard-free wiring, where every stage enable is tied high and only the redirect flush exists. It sits beside the IF_ID and ID_EX registers and tracks in-flight register writers in a shift-register scoreboard. From that it produces stall, bubble and flush controls plus registered EX-stage operand-forward selects.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register index width
- FWD_DEPTH, 3, tracked stages after ID (entry 0 = EX, 1 = ME, 2 = WB, ...); legal 2..8
- LOAD_LAT, 1, extra cycles after EX before load data is forwardable; legal 0..FWD_DEPTH-2
- SEL_W, $clog2(FWD_DEPTH), forward-select width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pipe_en_i  in  1  global advance; low freezes all state and outputs
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i / id_rs2_i  in  REG_ADDR_WIDTH  ID source indices
- id_rs1_use_i / id_rs2_use_i  in  1  source actually read
- id_rd_i  in  REG_ADDR_WIDTH  ID destination
- id_wb_en_i  in  1  ID writes rd
- id_is_load_i  in  1  ID is a load
- redirect_i  in  1  EX branch/jump taken this cycle
- stall_o  out  1  hold PC and IF_ID (combinational)
- bubble_o  out  1  load NOP controls into ID_EX (combinational)
- flush_if_id_o  out  1  replace IF_ID instruction with NOP (combinational)
- fwd_rs1_sel_o / fwd_rs2_sel_o  out  SEL_W  registered, valid for instruction now in EX; 0 = register file, k = stage-k result (1 = ME, 2 = WB, ...)
- stall_cnt_o  out  32  saturating count of stall cycles

## Operation
- Scoreboard: FWD_DEPTH entries {v, rd, ld}. An entry matches source s when v=1, rd==s, rd!=0 and the source-use bit is set.
- Hazard check for each used source: find the lowest matching k in 0..FWD_DEPTH-2. Entries at k=FWD_DEPTH-1 are ignored because they retire before the consumer reads.
- With forwarding:
  - Stall if the matching entry has ld=1 and k<LOAD_LAT.
  - Otherwise the next-cycle select is k+1.
  - No match gives select 0.
- Without forwarding: any match stalls.
- Priority: redirect_i overrides stall.
  - stall_o=0, flush_if_id_o=1, bubble_o=1.
  - The ID instruction is discarded.
  - Entries ≥0 already in flight are kept.
- bubble_o = stall_o | redirect_i. stall_o requires id_valid_i=1.
- Scoreboard advance when pipe_en_i=1:
  - Entry[k+1] <= entry[k].
  - Entry[0] <= {id_valid_i & id_wb_en_i & (id_rd_i!=0) & ~bubble_o, id_rd_i, id_is_load_i}.
  - The last entry drops off.
- Forward selects are registered on the same advance. They are forced to 0 when bubble_o=1.
- stall_cnt_o increments on each enabled cycle with stall_o=1 and saturates at 0xFFFFFFFF.
- pipe_en_i=0 freezes the scoreboard, the selects and the counter. stall_o, bubble_o and flush_if_id_o are forced to 0.

## Timing
- Reset: all scoreboard entries invalid, fwd selects 0, stall_cnt_o 0, combinational outputs 0. Reset asserted mid-stall clears the stall on the same cycle.
- Outputs are combinational from the ID inputs and current scoreboard. The selects have 1-cycle latency, aligned with ID_EX capture.
- Load-use with LOAD_LAT=1 costs exactly 1 stall cycle. The consumer then sees select 2 (WB).
- Without forwarding, a back-to-back dependency costs FWD_DEPTH-1 stall cycles.
- Simultaneous redirect and load-use: no stall, and the counter does not increment.
- rs1 and rs2 are evaluated independently. Either one stalling stalls the instruction. A stalled cycle assigns neither select.

## Configuration
- HAZARD_FORWARD_EN defined: forwarding paths and the load-latency stall rule are active.
- HAZARD_FORWARD_EN undefined: fwd selects are tied 0 and every in-flight match stalls. This is the area-minimal build for the regfile-only datapath.

## Test plan
- `addi x5` then `add x6,x5,x5` back-to-back (forwarding on) -> no stall; next cycle fwd_rs1_sel_o=fwd_rs2_sel_o=1.
- `lw x7` then `add x8,x7,x0` -> stall_o=1 for 1 cycle, stall_cnt_o=1; then fwd_rs1_sel_o=2.
- Forwarding off, FWD_DEPTH=3, dependent pair -> stall_o high 2 cycles, selects stay 0.
- Writer to x0 followed by a reader of x0 -> no stall, selects 0.
- Load-use hazard with redirect_i=1 in the same cycle -> stall_o=0, bubble_o=1, flush_if_id_o=1; the discarded writer never matches later.
- rst_n low mid-stall with a full scoreboard -> all outputs 0 immediately; a post-reset reader of the old rd does not stall.
